// File: rtl/ins_scheduler.sv
// Instruction scheduler: arbitrates four requesters into a 16-bit instruction stream
// with MIN_GAP idle cycles after each issue. Define INS_SCHED_FIXED_PRIO_EN for fixed priority.
module ins_scheduler #(
    parameter int unsigned MIN_GAP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req_valid,
    input  logic [47:0] req_data,
    output logic [3:0]  req_ready,
    output logic [15:0] ins,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [1:0]  grant_id,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0] GAP_LEN = 4'(MIN_GAP);

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  gap_cnt_r;
    logic [3:0]  gap_cnt_s;
    logic [15:0] ins_r;
    logic [15:0] ins_s;
    logic        ins_valid_r;
    logic        ins_valid_s;
    logic [1:0]  grant_r;
    logic [1:0]  grant_s;
    logic [3:0]  req_ready_s;
    logic [2:0]  arb_s;

`ifdef INS_SCHED_FIXED_PRIO_EN
    // Fixed priority: lowest asserted index wins; result is {found, index}.
    function automatic logic [2:0] arbitrate(input logic [3:0] valid);
        logic       found;
        logic [1:0] idx;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (valid[k]) begin
                found = 1'b1;
                idx   = 2'(k);
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction
`else
    logic [1:0] ptr_r;
    logic [1:0] ptr_s;

    // Round-robin: search ptr, ptr+1, ptr+2, ptr+3; result is {found, index}.
    function automatic logic [2:0] arbitrate(input logic [3:0] valid, input logic [1:0] ptr);
        logic       found;
        logic [1:0] idx;
        logic [1:0] cand;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && valid[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction
`endif

    // Extract the 12-bit payload of one requester.
    function automatic logic [11:0] payload(input logic [47:0] data, input logic [1:0] idx);
        return data[12*idx +: 12];
    endfunction

    // Next-state, accept strobe and instruction register update.
    always_comb begin
        state_s     = state_r;
        gap_cnt_s   = gap_cnt_r;
        ins_s       = ins_r;
        ins_valid_s = ins_valid_r;
        grant_s     = grant_r;
        req_ready_s = 4'd0;
`ifdef INS_SCHED_FIXED_PRIO_EN
        arb_s       = arbitrate(req_valid);
`else
        ptr_s       = ptr_r;
        arb_s       = arbitrate(req_valid, ptr_r);
`endif
        case (state_r)
            IDLE: begin
                if (arb_s[2]) begin
                    req_ready_s = 4'b0001 << arb_s[1:0];
                    ins_s       = {2'b00, arb_s[1:0], payload(req_data, arb_s[1:0])};
                    grant_s     = arb_s[1:0];
                    ins_valid_s = 1'b1;
                    state_s     = ISSUE;
                end else begin
                    state_s     = IDLE;
                end
            end
            ISSUE: begin
                if (ins_ready) begin
                    ins_valid_s = 1'b0;
`ifndef INS_SCHED_FIXED_PRIO_EN
                    ptr_s       = grant_r + 2'd1;
`endif
                    if (GAP_LEN != 4'd0) begin
                        state_s   = GAP;
                        gap_cnt_s = GAP_LEN - 4'd1;
                    end else begin
                        state_s   = IDLE;
                        gap_cnt_s = 4'd0;
                    end
                end else begin
                    state_s = ISSUE;
                end
            end
            GAP: begin
                if (gap_cnt_r == 4'd0) begin
                    state_s = IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r - 4'd1;
                end
            end
            default: begin
                state_s     = IDLE;
                ins_valid_s = 1'b0;
                gap_cnt_s   = 4'd0;
            end
        endcase
    end

    // State and output registers; reset abandons any pending instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            gap_cnt_r   <= 4'd0;
            ins_r       <= 16'h0000;
            ins_valid_r <= 1'b0;
            grant_r     <= 2'd0;
`ifndef INS_SCHED_FIXED_PRIO_EN
            ptr_r       <= 2'd0;
`endif
        end else begin
            state_r     <= state_s;
            gap_cnt_r   <= gap_cnt_s;
            ins_r       <= ins_s;
            ins_valid_r <= ins_valid_s;
            grant_r     <= grant_s;
`ifndef INS_SCHED_FIXED_PRIO_EN
            ptr_r       <= ptr_s;
`endif
        end
    end

    // Gating with rst_n keeps strobes quiet while reset is held, even before the first edge.
    assign req_ready = req_ready_s & {4{rst_n}};
    assign busy      = rst_n & (state_r != IDLE);
    assign ins       = ins_r;
    assign ins_valid = ins_valid_r;
    assign grant_id  = grant_r;

endmodule

// File: doc/ins_scheduler.md
INS_SCHEDULER -- requirements
Module: ins_scheduler

Interface
REQ-001 SHALL have parameter MIN_GAP, default 1, meaning idle cycles inserted after each accepted instruction (0..15).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port req_valid  input  4  per-requester request; bit i belongs to requester i.
REQ-005 SHALL have port req_data  input  48  per-requester 12-bit payload; requester i at bits [12i+11:12i].
REQ-006 SHALL have port req_ready  output  4  one-hot accept strobe; bit i high means requester i's payload is taken this cycle.
REQ-007 SHALL have port ins  output  16  instruction word to the channel decoder.
REQ-008 SHALL have port ins_valid  output  1  ins holds a valid instruction.
REQ-009 SHALL have port ins_ready  input  1  decoder consumes ins on a cycle where ins_valid and ins_ready are both high.
REQ-010 SHALL have port grant_id  output  2  index of the requester whose word is currently in ins.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, GAP.
REQ-013 IDLE: if any req_valid, SHALL select one requester g by the arbitration rule, assert req_ready[g] combinationally that cycle, and register ins = {2'b00, g[1:0], req_data[g]} and grant_id = g; next state ISSUE.
REQ-014 IDLE with req_valid == 0: req_ready SHALL be 0 and state SHALL remain IDLE.
REQ-015 req_ready SHALL be 0 in ISSUE and GAP, with at most one bit set in IDLE.
REQ-016 ISSUE: ins_valid SHALL be 1 and ins/grant_id SHALL be held stable until ins_ready is sampled high.
REQ-017 ISSUE with ins_ready high: next state SHALL be GAP with gap counter loaded to MIN_GAP-1 if MIN_GAP > 0, else IDLE; ins_valid SHALL be 0 from the following cycle.
REQ-018 GAP: counter SHALL decrement each cycle, and on reaching 0 the FSM SHALL go to IDLE; requests are neither accepted nor lost, because req_valid must be held by the requester.
REQ-019 ins_ready while ins_valid is 0 SHALL be ignored.
REQ-020 Round-robin: SHALL keep a 2-bit pointer p; search order p, p+1, p+2, p+3 (mod 4); first asserted req_valid wins; on each ISSUE handshake p SHALL become grant_id+1 (mod 4, 3 wraps to 0).
REQ-021 With all four requesters continuously valid, grants SHALL cycle 0,1,2,3,0,...
REQ-022 Throughput: one instruction per (2 + MIN_GAP) cycles maximum when ins_ready is held high.
REQ-023 ins[15:14] SHALL always be 2'b00, and ins[13:12] SHALL always equal grant_id.

Reset
REQ-024 On a rising clk edge with rst_n low: state SHALL become IDLE, ins 16'h0000, ins_valid 0, grant_id 0, pointer 0, and gap counter 0.
REQ-025 During reset cycles req_ready SHALL be 0 and busy SHALL be 0.
REQ-026 Reset asserted in ISSUE SHALL abandon the pending instruction without a handshake, and it SHALL NOT be reissued.

Configuration
REQ-027 Macro INS_SCHED_FIXED_PRIO_EN defined: arbitration SHALL be fixed priority, with the lowest index winning (0 > 1 > 2 > 3), and the pointer is unused.
REQ-028 Macro INS_SCHED_FIXED_PRIO_EN undefined: arbitration SHALL be round-robin per REQ-020; the interface is identical in both builds.

Verification
REQ-029 Reset: rst_n=0 for 2 cycles with req_valid=4'hF -> req_ready=0, ins=0, ins_valid=0, busy=0.
REQ-030 Single request: req_valid=4'b0100, data[2]=12'hABC, ins_ready=1, MIN_GAP=1 -> req_ready=4'b0100 in cycle 0; ins=16'h2ABC, ins_valid=1 in cycle 1; busy low again in cycle 3.
REQ-031 Backpressure: ins_ready=0 for 5 cycles in ISSUE -> ins, ins_valid and grant_id stable for all 5; the handshake occurs on the first cycle ins_ready=1.
REQ-032 Fairness (RR build): req_valid=4'hF held, ins_ready=1 -> grant_id sequence 0,1,2,3,0 with ins[13:12] matching; the FIXED_PRIO build yields 0,0,0,0.
REQ-033 Wrap/skip: pointer=3, req_valid=4'b0011 -> requester 0 is granted and the pointer then becomes 1.
REQ-034 Reset mid-ISSUE: drop rst_n while ins_valid=1 -> the next cycle has ins_valid=0, state IDLE, pointer 0, and no duplicate issue afterwards.
